// File: rtl/mem_access_ctrl.sv
// Load/store controller for a word-organised byte-lane memory: splits misaligned
// RV32 accesses into two word cycles and sign/zero-extends load data.
module mem_access_ctrl #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic                     rsp_err,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [3:0]               mem_be,
    output logic [DATA_WIDTH-1:0]    mem_din,
    input  logic [DATA_WIDTH-1:0]    mem_dout
);

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, WAIT, DONE} state_e;

    function automatic logic legal_f3(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // Byte enables for the low (hi=0) or high (hi=1) word of the two-word window.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off,
                                           input logic hi);
        logic [7:0] mask8;
        case (f3[1:0])
            2'b00:   mask8 = 8'h01;
            2'b01:   mask8 = 8'h03;
            default: mask8 = 8'h0F;
        endcase
        mask8 = mask8 << off;
        return hi ? mask8[7:4] : mask8[3:0];
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] wdata, input logic [1:0] off,
                                              input logic hi);
        logic [63:0] sh;
        sh = {32'b0, wdata} << {off, 3'b000};
        return hi ? sh[63:32] : sh[31:0];
    endfunction

    state_e                    state_q;
    logic                      we_q;
    logic [2:0]                funct3_q;
    logic [ADDRESS_WIDTH+1:0]  addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH-1:0]     w0_q;
    logic                      req_ready_q;
    logic                      rsp_valid_q;
    logic                      rsp_err_q;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q;
    logic [ADDRESS_WIDTH-1:0]  mem_addr_q;
    logic [3:0]                mem_be_q;
    logic [DATA_WIDTH-1:0]     mem_din_q;

    logic [ADDRESS_WIDTH-1:0]  req_wa;
    logic [ADDRESS_WIDTH-1:0]  wa_q;
    logic [1:0]                req_off;
    logic [1:0]                off_q;
    logic                      misaligned;
    logic [DATA_WIDTH-1:0]     lo_word;
    logic [DATA_WIDTH-1:0]     hi_word;
    logic [DATA_WIDTH-1:0]     merged;
    logic [DATA_WIDTH-1:0]     rsp_rdata_d;

    assign req_wa     = req_addr[ADDRESS_WIDTH+1:2];
    assign req_off    = req_addr[1:0];
    assign wa_q       = addr_q[ADDRESS_WIDTH+1:2];
    assign off_q      = addr_q[1:0];
    assign misaligned = |lane_be(funct3_q, off_q, 1'b1);

    // Load result, evaluated while in WAIT: mem_dout then holds the last word read.
    always_comb begin
        // NOTE: every always_comb output is assigned before any branch, so no
        // path can leave it holding its old value and no latch is inferred.
        lo_word     = misaligned ? w0_q : mem_dout;
        hi_word     = misaligned ? mem_dout : '0;
        merged      = 32'({hi_word, lo_word} >> {off_q, 3'b000});
        rsp_rdata_d = merged;
        case (funct3_q)
            3'b000:  rsp_rdata_d = {{24{merged[7]}}, merged[7:0]};
            3'b100:  rsp_rdata_d = {24'b0, merged[7:0]};
            3'b001:  rsp_rdata_d = {{16{merged[15]}}, merged[15:0]};
            3'b101:  rsp_rdata_d = {16'b0, merged[15:0]};
            default: rsp_rdata_d = merged;
        endcase
        if (we_q) begin
            rsp_rdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            w0_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_din_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // right-hand side reads the value from before this clock edge.
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        we_q        <= req_we;
                        funct3_q    <= req_funct3;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        mem_addr_q  <= req_wa;
                        if (legal_f3(req_funct3)) begin
                            state_q   <= ACC0;
                            mem_be_q  <= req_we ? lane_be(req_funct3, req_off, 1'b0) : 4'b0;
                            mem_din_q <= lane_data(req_wdata, req_off, 1'b0);
                        end else begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                ACC0: begin
                    if (misaligned) begin
                        state_q    <= ACC1;
                        mem_addr_q <= wa_q + 1'b1;
                        mem_be_q   <= we_q ? lane_be(funct3_q, off_q, 1'b1) : 4'b0;
                        mem_din_q  <= lane_data(wdata_q, off_q, 1'b1);
                    end else begin
                        state_q    <= WAIT;
                        mem_be_q   <= '0;
                        mem_din_q  <= '0;
                    end
                end
                ACC1: begin
                    state_q    <= WAIT;
                    w0_q       <= mem_dout;
                    mem_addr_q <= wa_q;
                    mem_be_q   <= '0;
                    mem_din_q  <= '0;
                end
                WAIT: begin
                    state_q     <= DONE;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= rsp_rdata_d;
                end
                DONE: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    mem_be_q    <= '0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-array reference model predicts every cycle of
// each access; a write-first word memory sits on the memory port.
module tb_mem_access_ctrl;

    localparam int AW = 4;

    typedef struct {
        logic          ready;
        logic          rv;
        logic          err;
        logic [31:0]   rdata;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   din;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'b0;
    logic [AW+1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_err;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;

    logic [31:0]   mem [16] = '{default: 32'h0};
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    ref_mem [64] = '{default: 8'h0};

    exp_t          exp_q[$];
    logic [AW-1:0] last_wa = '0;
    logic [31:0]   dut_last_rdata = '0;
    logic [3:0]    m_be0, m_be1;
    logic [31:0]   m_din0, m_din1, m_rdata;
    bit            m_mis;
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Write-first synchronous memory: read address registered, data follows the edge.
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (mem_be[l]) mem[mem_addr][l*8 +: 8] <= mem_din[l*8 +: 8];
        end
        rd_addr <= mem_addr;
    end
    assign mem_dout = mem[rd_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic ready, input logic rv, input logic err,
                                input logic [31:0] rdata, input logic [AW-1:0] addr,
                                input logic [3:0] be, input logic [31:0] din);
        exp_t e;
        e.ready = ready; e.rv = rv; e.err = err; e.rdata = rdata;
        e.addr = addr; e.be = be; e.din = din;
        return e;
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] be);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) r[l*8 +: 8] = {8{be[l]}};
        return r;
    endfunction

    // Reference model: walk the accessed bytes one by one and queue the
    // expected output of every cycle from the one after the accept edge.
    task automatic model_req(input bit we, input logic [2:0] f3, input logic [5:0] addr,
                             input logic [31:0] wd, input bit abort);
        int         n;
        logic [3:0] wa, wa1;
        logic [5:0] b;
        logic [31:0] v;
        wa = addr[5:2];
        wa1 = wa + 4'd1;
        last_wa = wa;
        m_be0 = '0; m_be1 = '0; m_din0 = '0; m_din1 = '0; m_mis = 0; v = '0;
        if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) begin
            m_rdata = '0;
            exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 32'h0, wa, 4'h0, 32'h0));
            return;
        end
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            b = addr + 6'(i);
            v[i*8 +: 8] = ref_mem[b];
            if (b[5:2] == wa) begin
                m_be0[b[1:0]] = 1'b1;
                m_din0[b[1:0]*8 +: 8] = wd[i*8 +: 8];
            end else begin
                m_mis = 1;
                m_be1[b[1:0]] = 1'b1;
                m_din1[b[1:0]*8 +: 8] = wd[i*8 +: 8];
            end
        end
        if (n < 4 && !f3[2]) begin
            for (int k = n * 8; k < 32; k++) v[k] = v[n*8-1];
        end
        m_rdata = we ? 32'h0 : v;
        if (we) begin
            for (int i = 0; i < n; i++) begin
                b = addr + 6'(i);
                if (!abort || b[5:2] == wa) ref_mem[b] = wd[i*8 +: 8];
            end
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, wa, we ? m_be0 : 4'h0, m_din0));
        if (abort) return;
        if (m_mis) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, wa1, we ? m_be1 : 4'h0, m_din1));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, wa, 4'h0, 32'h0));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, m_rdata, wa, 4'h0, 32'h0));
    endtask

    // Single compare process: every out-of-reset cycle is checked, idle or busy.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = mk(1'b1, 1'b0, 1'b0, 32'h0, last_wa, 4'h0, 32'h0);
            check("req_ready", req_ready, e.ready);
            check("rsp_valid", rsp_valid, e.rv);
            check("rsp_err", rsp_err, e.err);
            check("mem_addr", mem_addr, e.addr);
            check("mem_be", mem_be, e.be);
            if (e.be != 4'h0) check("mem_din", mem_din & lane_bits(e.be), e.din & lane_bits(e.be));
            if (e.rv) begin
                check("rsp_rdata", rsp_rdata, e.rdata);
                dut_last_rdata = rsp_rdata;
            end
        end
    end

    task automatic do_req(input bit we, input logic [2:0] f3, input logic [5:0] addr,
                          input logic [31:0] wd, input bit hold, input bit abort);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        model_req(we, f3, addr, wd, abort);
        if (hold) begin
            req_we = ~we; req_funct3 = 3'b010; req_addr = ~addr; req_wdata = ~wd;
            repeat (2) begin @(posedge clk); #1; end
        end
        req_valid = 1'b0;
        if (!abort) begin
            for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
                @(negedge clk);
                #1;
            end
            check("drain", exp_q.size(), 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, req_ready, 1);
        check({tag, " rsp_valid"}, rsp_valid, 0);
        check({tag, " rsp_err"}, rsp_err, 0);
        check({tag, " rsp_rdata"}, rsp_rdata, 0);
        check({tag, " mem_be"}, mem_be, 0);
        check({tag, " mem_addr"}, mem_addr, 0);
        check({tag, " mem_din"}, mem_din, 0);
    endtask

    initial begin
        #12;
        check_reset_outputs("por");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Aligned word store, then loads of every width from the same word.
        do_req(1, 3'b010, 6'h08, 32'hDEADBEEF, 0, 0);
        check("model sw be0", m_be0, 4'hF);
        check("model sw din0", m_din0, 32'hDEADBEEF);
        do_req(0, 3'b000, 6'h0B, 32'h0, 0, 0);
        check("lb 0x0b", dut_last_rdata, 32'hFFFFFFDE);
        do_req(0, 3'b100, 6'h0B, 32'h0, 0, 0);
        check("lbu 0x0b", dut_last_rdata, 32'h000000DE);
        do_req(0, 3'b101, 6'h0A, 32'h0, 0, 0);
        check("lhu 0x0a", dut_last_rdata, 32'h0000DEAD);
        do_req(0, 3'b001, 6'h0A, 32'h0, 0, 0);
        do_req(0, 3'b010, 6'h08, 32'h0, 0, 0);

        // Misaligned word store split over words 3 and 4, read back while req_valid is held.
        do_req(1, 3'b010, 6'h0E, 32'h11223344, 0, 0);
        check("model msw be0", m_be0, 4'b1100);
        check("model msw be1", m_be1, 4'b0011);
        check("model msw din0", m_din0[31:16], 16'h3344);
        check("model msw din1", m_din1[15:0], 16'h1122);
        do_req(0, 3'b010, 6'h0E, 32'h0, 1, 0);
        check("lw 0x0e", dut_last_rdata, 32'h11223344);

        // Wrap from word 15 to word 0.
        do_req(1, 3'b000, 6'h3F, 32'h000000AB, 0, 0);
        do_req(1, 3'b000, 6'h00, 32'h000000CD, 0, 0);
        do_req(0, 3'b001, 6'h3F, 32'h0, 0, 0);
        check("lh 0x3f", dut_last_rdata, 32'hFFFFCDAB);
        do_req(0, 3'b101, 6'h3F, 32'h0, 0, 0);
        check("lhu 0x3f", dut_last_rdata, 32'h0000CDAB);

        // Illegal size codes.
        do_req(1, 3'b011, 6'h10, 32'h55555555, 0, 0);
        check("illegal rdata", dut_last_rdata, 32'h0);
        do_req(0, 3'b110, 6'h21, 32'h0, 0, 0);
        do_req(0, 3'b111, 6'h33, 32'h0, 0, 0);

        // Half-words inside one word and across a word boundary.
        do_req(1, 3'b001, 6'h01, 32'h0000BEEF, 0, 0);
        do_req(0, 3'b010, 6'h00, 32'h0, 0, 0);
        do_req(1, 3'b001, 6'h03, 32'h00001234, 0, 0);
        do_req(0, 3'b101, 6'h03, 32'h0, 0, 0);
        check("lhu 0x03", dut_last_rdata, 32'h00001234);
        do_req(0, 3'b000, 6'h04, 32'h0, 0, 0);

        // Reset during ACC1 of a misaligned store: only the ACC0 half lands.
        do_req(1, 3'b010, 6'h0E, 32'hCAFEF00D, 0, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        last_wa = '0;
        exp_q.delete();
        #1;
        check_reset_outputs("mid-op reset");
        check("word3 upper", mem[3][31:16], 16'hF00D);
        check("word4 lower", mem[4][15:0], 16'h1122);
        check("word4 vs model", mem[4][15:0], {ref_mem[17], ref_mem[16]});
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_req(0, 3'b010, 6'h0E, 32'h0, 0, 0);
        check("lw after reset", dut_last_rdata, 32'h1122F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 4: word-address width of the controlled byte-lane memory.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width; only 32 is supported.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  async active-low reset.
REQ-006 req_valid  in  1  request present; req_ready  out  1  controller idle and accepting.
REQ-007 req_we  in  1  1=store, 0=load.
REQ-008 req_funct3  in  3  RV32 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  in  ADDRESS_WIDTH+2  byte address; req_wdata  in  32  store data, right-justified.
REQ-010 rsp_valid  out  1  one-cycle completion pulse; rsp_err  out  1  illegal funct3 (valid with rsp_valid).
REQ-011 rsp_rdata  out  32  extended load data (0 for stores and errors).
REQ-012 mem_addr  out  ADDRESS_WIDTH; mem_be  out  4; mem_din  out  32: drive memory word address, per-byte write enables and write data.
REQ-013 mem_dout  in  32  memory read word for the address sampled at the previous rising edge (write-first).

Function
REQ-014 SHALL accept a request on a rising edge where req_valid && req_ready, latching all req_* fields.
REQ-015 SHALL assert req_ready only in IDLE.
REQ-016 FSM states: IDLE, ACC0, ACC1, WAIT, DONE.
REQ-017 Transitions: IDLE->ACC0 on accept; ACC0->ACC1 if misaligned, else WAIT; ACC1->WAIT; WAIT->DONE; DONE->IDLE; illegal funct3: IDLE->DONE directly.
REQ-018 off = addr[1:0]; wa = addr[ADDRESS_WIDTH+1:2]; mask = 1/3/15 for B/H/W sizes; mask8 = mask << off; misaligned iff mask8[7:4] != 0.
REQ-019 ACC0: mem_addr = wa; ACC1: mem_addr = (wa+1) mod 2^ADDRESS_WIDTH (wrap-around); other states: mem_addr = wa of the last request.
REQ-020 Stores: mem_be = mask8[3:0] in ACC0, mask8[7:4] in ACC1; sh = {32'b0,wdata} << 8*off; mem_din = sh[31:0] in ACC0, sh[63:32] in ACC1.
REQ-021 mem_be SHALL be 0 for loads, for illegal funct3, and in IDLE/WAIT/DONE; mem_din is don't-care while mem_be = 0.
REQ-022 Loads: w0 = mem_dout captured in ACC1 (misaligned) or WAIT (aligned); w1 = mem_dout captured in WAIT (misaligned only, else 0); m = ({w1,w0} >> 8*off)[31:0].
REQ-023 rsp_rdata: B sign-extends m[7:0]; BU zero-extends m[7:0]; H sign-extends m[15:0]; HU zero-extends m[15:0]; W = m; registered; valid only in DONE.
REQ-024 rsp_valid SHALL be 1 exactly in DONE. Latency from the accept edge: aligned 3 cycles, misaligned 4, illegal 1.
REQ-025 Illegal funct3 (011, 110, 111) SHALL produce no memory write, rsp_err = 1 and rsp_rdata = 0.
REQ-026 rsp_err SHALL be 0 whenever rsp_valid = 0.
REQ-027 req_valid outside IDLE SHALL be ignored; the requester holds it until accepted.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_be=0, mem_addr=0, mem_din=0, and clear all latched request fields.
REQ-029 Reset mid-operation SHALL abandon the request with no response. Byte writes already clocked into memory in ACC0 are not undone.
REQ-030 After rst_n deasserts, the first accept SHALL occur no earlier than the next rising edge.

Verification
REQ-031 Aligned SW: addr 0x08, wdata 0xDEADBEEF -> ACC0: mem_addr=2, mem_be=1111, mem_din=0xDEADBEEF; rsp_valid 3 cycles after accept.
REQ-032 Aligned loads: word 2 = 0xDEADBEEF; LB addr 0x0B -> 0xFFFFFFDE; LBU -> 0x000000DE; LHU addr 0x0A -> 0x0000DEAD.
REQ-033 Misaligned SW: addr 0x0E, wdata 0x11223344 -> ACC0: addr 3, be=1100, din[31:16]=0x3344; ACC1: addr 4, be=0011, din[15:0]=0x1122; a following LW at 0x0E returns 0x11223344, rsp 4 cycles after accept.
REQ-034 Wrap-around: LH at byte addr 0x3F (ADDRESS_WIDTH=4) -> ACC1 mem_addr=0; the result merges byte 3 of word 15 with byte 0 of word 0.
REQ-035 Illegal funct3 011 store -> mem_be stays 0; rsp_valid and rsp_err =1 one cycle after accept; rsp_rdata=0.
REQ-036 Reset in ACC1 of a misaligned store -> outputs at reset values the same cycle; no rsp_valid; word3 upper bytes written, word4 unchanged.
